// File: rtl/ex_operand_stage_if.sv
// ex_operand_stage_if: bus between ID, the ID/EX operand stage, the MEM/WB producers and the ALU.
// Groups: ID offer (id_*), pipeline control (flush), producers (mem_*, wb_*), ALU side (ex_*).
// master = surrounding pipeline (drives ID offer, flush, producers, ex_ready).
// slave  = the operand stage (drives id_ready and the ex_* outputs).
interface ex_operand_stage_if #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
);
  logic             id_valid;
  logic             id_ready;
  logic [RADDR-1:0] id_rs_addr;
  logic [RADDR-1:0] id_rt_addr;
  logic [XLEN-1:0]  id_rs_data;
  logic [XLEN-1:0]  id_rt_data;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [15:0]      id_imm;
  logic             id_imm_zext;
  logic             id_src_b_imm;
  logic             id_src_a_shamt;
  logic [4:0]       id_shamt;
  logic [3:0]       id_alu_op;
  logic [RADDR-1:0] id_dest_addr;
  logic             id_reg_write;
  logic             id_is_load;
  logic             flush;
  logic             mem_reg_write;
  logic [RADDR-1:0] mem_dest_addr;
  logic [XLEN-1:0]  mem_result;
  logic             wb_reg_write;
  logic [RADDR-1:0] wb_dest_addr;
  logic [XLEN-1:0]  wb_result;
  logic             ex_valid;
  logic             ex_ready;
  logic [XLEN-1:0]  ex_in1;
  logic [XLEN-1:0]  ex_in2;
  logic [3:0]       ex_op;
  logic [RADDR-1:0] ex_dest_addr;
  logic             ex_reg_write;
  logic             ex_is_load;
  modport master (
    output id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data, id_use_rs, id_use_rt,
           id_imm, id_imm_zext, id_src_b_imm, id_src_a_shamt, id_shamt, id_alu_op,
           id_dest_addr, id_reg_write, id_is_load, flush,
           mem_reg_write, mem_dest_addr, mem_result, wb_reg_write, wb_dest_addr, wb_result,
           ex_ready,
    input  id_ready, ex_valid, ex_in1, ex_in2, ex_op, ex_dest_addr, ex_reg_write, ex_is_load
  );
  modport slave (
    input  id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data, id_use_rs, id_use_rt,
           id_imm, id_imm_zext, id_src_b_imm, id_src_a_shamt, id_shamt, id_alu_op,
           id_dest_addr, id_reg_write, id_is_load, flush,
           mem_reg_write, mem_dest_addr, mem_result, wb_reg_write, wb_dest_addr, wb_result,
           ex_ready,
    output id_ready, ex_valid, ex_in1, ex_in2, ex_op, ex_dest_addr, ex_reg_write, ex_is_load
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register building the ALU operands (In1, In2, OP).
// Ports: clk, rst (async, active-high), bus (ex_operand_stage_if.slave):
//   ID side valid/ready offer, flush, MEM/WB producer results, ALU side valid/ready outputs.
// Option: define EX_FWD_EN for the MEM/WB forwarding mux on the registered operands; when
//   undefined, any pending producer match (stage or MEM) stalls ID instead.
module ex_operand_stage #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input logic clk,
  input logic rst,
  ex_operand_stage_if.slave bus
);
  logic             valid_q;
  logic [XLEN-1:0]  opa_q;
  logic [XLEN-1:0]  opb_q;
  logic [3:0]       op_q;
  logic [RADDR-1:0] dest_q;
  logic             reg_write_q;
  logic             is_load_q;
  logic             ex_match;
  logic             hazard;
  logic             ready;
  logic             load;
  logic [XLEN-1:0]  rs_val;
  logic [XLEN-1:0]  rt_val;
  logic [XLEN-1:0]  imm_ext;
  logic [XLEN-1:0]  shamt_ext;
  // True when ID actually reads the register the held instruction will write ($0 never matches).
  assign ex_match = dest_q != '0 &&
                    ((bus.id_use_rs && bus.id_rs_addr == dest_q) ||
                     (bus.id_use_rt && bus.id_rt_addr == dest_q));
`ifdef EX_FWD_EN
  logic             a_reg_q;
  logic             b_reg_q;
  logic [RADDR-1:0] rs_addr_q;
  logic [RADDR-1:0] rt_addr_q;
  // MEM wins over WB because it holds the younger result.
  function automatic logic [XLEN-1:0] fwd(
    input logic [RADDR-1:0] a, input logic [XLEN-1:0] d,
    input logic mw, input logic [RADDR-1:0] ma, input logic [XLEN-1:0] mr,
    input logic ww, input logic [RADDR-1:0] wa, input logic [XLEN-1:0] wr
  );
    return a == '0 ? d : (mw && ma == a) ? mr : (ww && wa == a) ? wr : d;
  endfunction
  // Only a load's data is still unavailable for forwarding.
  assign hazard = valid_q && is_load_q && ex_match;
  // Combinational on the held registers, so a stalled entry keeps picking up producer updates.
  assign bus.ex_in1 = a_reg_q ? fwd(rs_addr_q, opa_q, bus.mem_reg_write, bus.mem_dest_addr,
                                    bus.mem_result, bus.wb_reg_write, bus.wb_dest_addr,
                                    bus.wb_result) : opa_q;
  assign bus.ex_in2 = b_reg_q ? fwd(rt_addr_q, opb_q, bus.mem_reg_write, bus.mem_dest_addr,
                                    bus.mem_result, bus.wb_reg_write, bus.wb_dest_addr,
                                    bus.wb_result) : opb_q;
`else
  logic mem_match;
  assign mem_match = bus.mem_dest_addr != '0 &&
                     ((bus.id_use_rs && bus.id_rs_addr == bus.mem_dest_addr) ||
                      (bus.id_use_rt && bus.id_rt_addr == bus.mem_dest_addr));
  // Without forwarding every in-flight producer ahead of WB must drain first; WB is covered
  // by the write-through register file.
  assign hazard = (valid_q && (is_load_q || reg_write_q) && ex_match) ||
                  (bus.mem_reg_write && mem_match);
  assign bus.ex_in1 = opa_q;
  assign bus.ex_in2 = opb_q;
`endif
  assign ready        = !bus.flush && !hazard && (!valid_q || bus.ex_ready);
  assign load         = bus.id_valid && ready;
  assign rs_val       = bus.id_rs_addr == '0 ? '0 : bus.id_rs_data;
  assign rt_val       = bus.id_rt_addr == '0 ? '0 : bus.id_rt_data;
  assign imm_ext      = bus.id_imm_zext ? {{(XLEN-16){1'b0}}, bus.id_imm}
                                        : {{(XLEN-16){bus.id_imm[15]}}, bus.id_imm};
  assign shamt_ext    = {{(XLEN-5){1'b0}}, bus.id_shamt};
  assign bus.id_ready     = ready;
  assign bus.ex_valid     = valid_q;
  assign bus.ex_op        = op_q;
  assign bus.ex_dest_addr = dest_q;
  assign bus.ex_reg_write = valid_q && reg_write_q;
  assign bus.ex_is_load   = valid_q && is_load_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid_q     <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      op_q        <= '0;
      dest_q      <= '0;
      reg_write_q <= 1'b0;
      is_load_q   <= 1'b0;
`ifdef EX_FWD_EN
      a_reg_q     <= 1'b0;
      b_reg_q     <= 1'b0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
`endif
    end else if (bus.flush)
      valid_q <= 1'b0;
    else if (load) begin
      valid_q     <= 1'b1;
      opa_q       <= bus.id_src_a_shamt ? shamt_ext : rs_val;
      opb_q       <= bus.id_src_b_imm ? imm_ext : rt_val;
      op_q        <= bus.id_alu_op;
      dest_q      <= bus.id_dest_addr;
      reg_write_q <= bus.id_reg_write;
      is_load_q   <= bus.id_is_load;
`ifdef EX_FWD_EN
      a_reg_q     <= !bus.id_src_a_shamt;
      b_reg_q     <= !bus.id_src_b_imm;
      rs_addr_q   <= bus.id_rs_addr;
      rt_addr_q   <= bus.id_rt_addr;
`endif
    end else if (bus.ex_ready)
      valid_q <= 1'b0;
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed scenarios plus randomized run against a cycle-level reference model.
module tb_ex_operand_stage;
`ifdef EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  typedef struct packed {
    logic [31:0] v1;
    logic [31:0] v2;
    logic        a_reg;
    logic        b_reg;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [3:0]  op;
    logic        rw;
    logic        ld;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  ex_operand_stage_if #(.XLEN(32), .RADDR(5)) b ();
  ex_operand_stage #(.XLEN(32), .RADDR(5)) dut (.clk(clk), .rst(rst), .bus(b));
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic clear_id;
    b.id_valid = 0; b.id_rs_addr = 0; b.id_rt_addr = 0; b.id_rs_data = 0; b.id_rt_data = 0;
    b.id_use_rs = 0; b.id_use_rt = 0; b.id_imm = 0; b.id_imm_zext = 0; b.id_src_b_imm = 0;
    b.id_src_a_shamt = 0; b.id_shamt = 0; b.id_alu_op = 0; b.id_dest_addr = 0;
    b.id_reg_write = 0; b.id_is_load = 0; b.flush = 0;
    b.mem_reg_write = 0; b.mem_dest_addr = 0; b.mem_result = 0;
    b.wb_reg_write = 0; b.wb_dest_addr = 0; b.wb_result = 0;
  endtask
  task automatic set_regs(input logic [4:0] rs, input logic [31:0] rsd, input logic [4:0] rt,
                          input logic [31:0] rtd, input logic urs, input logic urt);
    b.id_rs_addr = rs; b.id_rs_data = rsd; b.id_rt_addr = rt; b.id_rt_data = rtd;
    b.id_use_rs = urs; b.id_use_rt = urt;
  endtask
  task automatic set_ctl(input logic [15:0] imm, input logic zext, input logic bimm,
                         input logic ash, input logic [4:0] sh, input logic [3:0] op,
                         input logic [4:0] dest, input logic rw, input logic ld);
    b.id_imm = imm; b.id_imm_zext = zext; b.id_src_b_imm = bimm; b.id_src_a_shamt = ash;
    b.id_shamt = sh; b.id_alu_op = op; b.id_dest_addr = dest; b.id_reg_write = rw;
    b.id_is_load = ld;
  endtask
  // Leaves the stage empty and the bench sitting on a falling edge.
  task automatic idle;
    @(negedge clk); clear_id(); b.ex_ready = 1;
    @(negedge clk);
  endtask
  task automatic test_reset;
    clear_id(); b.ex_ready = 1; rst = 1;
    repeat (2) @(negedge clk);
    rst = 0; #1;
    tests++; if (b.ex_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", b.ex_valid); end
    tests++; if (b.ex_in1 !== 32'h0) begin fails++; $display("FAIL reset_in1: got %h want 0", b.ex_in1); end
    tests++; if (b.ex_in2 !== 32'h0) begin fails++; $display("FAIL reset_in2: got %h want 0", b.ex_in2); end
    tests++; if (b.ex_op !== 4'h0) begin fails++; $display("FAIL reset_op: got %h want 0", b.ex_op); end
    tests++; if (b.ex_reg_write !== 1'b0 || b.ex_is_load !== 1'b0 || b.ex_dest_addr !== 5'd0) begin fails++; $display("FAIL reset_ctl: got rw=%b ld=%b dest=%0d want 0/0/0", b.ex_reg_write, b.ex_is_load, b.ex_dest_addr); end
    tests++; if (b.id_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", b.id_ready); end
  endtask
  task automatic test_addi;
    set_regs(5'd1, 32'd5, 5'd2, 32'h77, 1, 0);
    set_ctl(16'hFFFE, 0, 1, 0, 0, 4'h0, 5'd3, 1, 0);
    b.id_valid = 1; #1;
    tests++; if (b.id_ready !== 1'b1) begin fails++; $display("FAIL addi_ready: got %b want 1", b.id_ready); end
    @(negedge clk); b.id_valid = 0; #1;
    tests++; if (b.ex_valid !== 1'b1) begin fails++; $display("FAIL addi_valid: got %b want 1", b.ex_valid); end
    tests++; if (b.ex_in1 !== 32'd5) begin fails++; $display("FAIL addi_in1: got %h want 5", b.ex_in1); end
    tests++; if (b.ex_in2 !== 32'hFFFFFFFE) begin fails++; $display("FAIL addi_in2: got %h want fffffffe", b.ex_in2); end
    tests++; if (b.ex_dest_addr !== 5'd3 || b.ex_reg_write !== 1'b1 || b.ex_op !== 4'h0) begin fails++; $display("FAIL addi_ctl: got dest=%0d rw=%b op=%h want 3/1/0", b.ex_dest_addr, b.ex_reg_write, b.ex_op); end
  endtask
  task automatic test_ori;
    set_regs(5'd0, 32'hDEADBEEF, 5'd0, 32'h0, 1, 0);
    set_ctl(16'h8001, 1, 1, 0, 0, 4'h5, 5'd4, 1, 0);
    b.id_valid = 1;
    @(negedge clk); b.id_valid = 0; #1;
    tests++; if (b.ex_in2 !== 32'h00008001) begin fails++; $display("FAIL ori_in2: got %h want 00008001", b.ex_in2); end
    tests++; if (b.ex_in1 !== 32'h0) begin fails++; $display("FAIL ori_r0: got %h want 0", b.ex_in1); end
    tests++; if (b.ex_op !== 4'h5) begin fails++; $display("FAIL ori_op: got %h want 5", b.ex_op); end
  endtask
  task automatic test_sll;
    set_regs(5'd7, 32'hCAFE, 5'd3, 32'd1, 0, 1);
    set_ctl(16'h0, 0, 0, 1, 5'd3, 4'h8, 5'd5, 1, 0);
    b.id_valid = 1;
    @(negedge clk); b.id_valid = 0; #1;
    tests++; if (b.ex_in1 !== 32'd3) begin fails++; $display("FAIL sll_in1: got %h want 3", b.ex_in1); end
    tests++; if (b.ex_in2 !== 32'd1) begin fails++; $display("FAIL sll_in2: got %h want 1", b.ex_in2); end
  endtask
  task automatic test_back_to_back;
    set_regs(5'd1, 32'h100, 5'd0, 32'h0, 0, 0);
    set_ctl(16'h0, 0, 1, 0, 0, 4'h0, 5'd2, 1, 0);
    b.id_valid = 1; b.ex_ready = 0;
    @(negedge clk); b.id_rs_data = 32'h101; #1;
    tests++; if (b.id_ready !== 1'b0 || b.ex_in1 !== 32'h100) begin fails++; $display("FAIL b2b_stall1: got ready=%b in1=%h want 0/100", b.id_ready, b.ex_in1); end
    @(negedge clk); #1;
    tests++; if (b.id_ready !== 1'b0 || b.ex_valid !== 1'b1 || b.ex_in1 !== 32'h100) begin fails++; $display("FAIL b2b_stall2: got ready=%b valid=%b in1=%h want 0/1/100", b.id_ready, b.ex_valid, b.ex_in1); end
    @(negedge clk); b.ex_ready = 1; #1;
    tests++; if (b.id_ready !== 1'b1) begin fails++; $display("FAIL b2b_release: got %b want 1", b.id_ready); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); b.id_rs_data = 32'h101 + 32'(k); b.id_valid = k < 3; #1;
      tests++; if (b.ex_valid !== 1'b1 || b.ex_in1 !== 32'h100 + 32'(k)) begin fails++; $display("FAIL b2b_stream%0d: got valid=%b in1=%h want 1/%h", k, b.ex_valid, b.ex_in1, 32'h100 + 32'(k)); end
    end
  endtask
  task automatic test_load_use;
    set_regs(5'd2, 32'h55, 5'd0, 32'h0, 1, 0);
    set_ctl(16'h10, 0, 1, 0, 0, 4'h0, 5'd8, 1, 1);
    b.id_valid = 1; b.ex_ready = 1;
    @(negedge clk);
    set_regs(5'd8, 32'hDEAD, 5'd0, 32'h0, 1, 0);
    set_ctl(16'h0, 0, 1, 0, 0, 4'h0, 5'd9, 1, 0); #1;
    tests++; if (b.id_ready !== 1'b0 || b.ex_is_load !== 1'b1) begin fails++; $display("FAIL lu_stall: got ready=%b ld=%b want 0/1", b.id_ready, b.ex_is_load); end
    @(negedge clk); #1;
    tests++; if (b.id_ready !== 1'b1 || b.ex_valid !== 1'b0) begin fails++; $display("FAIL lu_resume: got ready=%b valid=%b want 1/0", b.id_ready, b.ex_valid); end
    @(negedge clk); b.id_valid = 0; b.wb_reg_write = 1; b.wb_dest_addr = 5'd8; b.wb_result = 32'h1234; #1;
    tests++; if (b.ex_valid !== 1'b1 || b.ex_in1 !== (FWD ? 32'h1234 : 32'hDEAD)) begin fails++; $display("FAIL lu_operand: got valid=%b in1=%h want 1/%h", b.ex_valid, b.ex_in1, FWD ? 32'h1234 : 32'hDEAD); end
    idle();
    set_regs(5'd3, 32'h1, 5'd0, 32'h0, 0, 0);
    set_ctl(16'h0, 0, 1, 0, 0, 4'h0, 5'd0, 1, 1);
    b.id_valid = 1;
    @(negedge clk); set_regs(5'd0, 32'h5, 5'd0, 32'h0, 1, 1); #1;
    tests++; if (b.id_ready !== 1'b1) begin fails++; $display("FAIL lu_r0: got %b want 1", b.id_ready); end
  endtask
  task automatic test_producer_hazard;
    set_regs(5'd1, 32'h1, 5'd0, 32'h0, 0, 0);
    set_ctl(16'h0, 0, 1, 0, 0, 4'h0, 5'd6, 1, 0);
    b.id_valid = 1; b.ex_ready = 1;
    @(negedge clk); set_regs(5'd6, 32'h1, 5'd0, 32'h0, 1, 0); #1;
    tests++; if (b.id_ready !== FWD) begin fails++; $display("FAIL haz_ex: got %b want %b", b.id_ready, FWD); end
    idle();
    b.mem_reg_write = 1; b.mem_dest_addr = 5'd7;
    set_regs(5'd0, 32'h0, 5'd7, 32'h2, 0, 1); #1;
    tests++; if (b.id_ready !== FWD) begin fails++; $display("FAIL haz_mem: got %b want %b", b.id_ready, FWD); end
    b.id_use_rt = 0; #1;
    tests++; if (b.id_ready !== 1'b1) begin fails++; $display("FAIL haz_unused: got %b want 1", b.id_ready); end
  endtask
`ifdef EX_FWD_EN
  task automatic test_fwd_priority;
    set_regs(5'd9, 32'h11, 5'd9, 32'h22, 1, 1);
    set_ctl(16'h0, 0, 0, 0, 0, 4'h0, 5'd10, 1, 0);
    b.id_valid = 1; b.ex_ready = 0;
    @(negedge clk); b.id_valid = 0;
    b.mem_reg_write = 1; b.mem_dest_addr = 5'd9; b.mem_result = 32'd7;
    b.wb_reg_write = 1; b.wb_dest_addr = 5'd9; b.wb_result = 32'd3; #1;
    tests++; if (b.ex_in1 !== 32'd7 || b.ex_in2 !== 32'd7) begin fails++; $display("FAIL fwd_mem: got %h/%h want 7/7", b.ex_in1, b.ex_in2); end
    @(negedge clk); b.mem_reg_write = 0; #1;
    tests++; if (b.ex_in1 !== 32'd3 || b.ex_in2 !== 32'd3) begin fails++; $display("FAIL fwd_wb: got %h/%h want 3/3", b.ex_in1, b.ex_in2); end
    @(negedge clk); b.wb_reg_write = 0; #1;
    tests++; if (b.ex_in1 !== 32'h11 || b.ex_in2 !== 32'h22) begin fails++; $display("FAIL fwd_none: got %h/%h want 11/22", b.ex_in1, b.ex_in2); end
    @(negedge clk); clear_id(); b.ex_ready = 1;
    set_regs(5'd0, 32'h99, 5'd0, 32'h98, 1, 1);
    set_ctl(16'h0, 0, 0, 0, 0, 4'h0, 5'd10, 1, 0);
    b.id_valid = 1;
    @(negedge clk); b.id_valid = 0;
    b.mem_reg_write = 1; b.mem_dest_addr = 5'd0; b.mem_result = 32'd7;
    b.wb_reg_write = 1; b.wb_dest_addr = 5'd0; b.wb_result = 32'd3; #1;
    tests++; if (b.ex_in1 !== 32'h0 || b.ex_in2 !== 32'h0) begin fails++; $display("FAIL fwd_r0: got %h/%h want 0/0", b.ex_in1, b.ex_in2); end
  endtask
`endif
  task automatic test_flush;
    set_regs(5'd1, 32'hA1, 5'd0, 32'h0, 0, 0);
    set_ctl(16'h0, 0, 1, 0, 0, 4'h2, 5'd11, 1, 0);
    b.id_valid = 1; b.ex_ready = 1;
    @(negedge clk); b.id_rs_data = 32'hB2; b.flush = 1; b.ex_ready = 0; #1;
    tests++; if (b.id_ready !== 1'b0 || b.ex_valid !== 1'b1) begin fails++; $display("FAIL flush_cycle: got ready=%b valid=%b want 0/1", b.id_ready, b.ex_valid); end
    @(negedge clk); b.flush = 0; b.id_valid = 0; #1;
    tests++; if (b.ex_valid !== 1'b0 || b.ex_reg_write !== 1'b0) begin fails++; $display("FAIL flush_kill: got valid=%b rw=%b want 0/0", b.ex_valid, b.ex_reg_write); end
    tests++; if (b.ex_in1 !== 32'hA1) begin fails++; $display("FAIL flush_nocapture: got %h want a1", b.ex_in1); end
  endtask
  task automatic test_async_reset;
    set_regs(5'd1, 32'hC3, 5'd0, 32'h0, 0, 0);
    set_ctl(16'h0, 0, 1, 0, 0, 4'h3, 5'd12, 1, 0);
    b.id_valid = 1; b.ex_ready = 0;
    @(negedge clk); #1;
    tests++; if (b.ex_valid !== 1'b1 || b.id_ready !== 1'b0) begin fails++; $display("FAIL arst_pre: got valid=%b ready=%b want 1/0", b.ex_valid, b.id_ready); end
    #2 rst = 1; #1;
    tests++; if (b.ex_valid !== 1'b0 || b.ex_in1 !== 32'h0 || b.ex_op !== 4'h0 || b.ex_dest_addr !== 5'd0) begin fails++; $display("FAIL arst_now: got valid=%b in1=%h op=%h dest=%0d want 0/0/0/0", b.ex_valid, b.ex_in1, b.ex_op, b.ex_dest_addr); end
    @(negedge clk); rst = 0; b.ex_ready = 1; #1;
    tests++; if (b.id_ready !== 1'b1 || b.ex_valid !== 1'b0) begin fails++; $display("FAIL arst_post: got ready=%b valid=%b want 1/0", b.id_ready, b.ex_valid); end
  endtask
  function automatic bit hit(input logic [4:0] a);
    return a != 0 && ((b.id_use_rs && b.id_rs_addr == a) || (b.id_use_rt && b.id_rt_addr == a));
  endfunction
  function automatic logic [31:0] fwd_m(input logic [4:0] a, input logic [31:0] d);
    if (a == 0) return d;
    if (b.mem_reg_write && b.mem_dest_addr == a) return b.mem_result;
    if (b.wb_reg_write && b.wb_dest_addr == a) return b.wb_result;
    return d;
  endfunction
  task automatic test_random;
    ent_t e = '0;
    ent_t ne;
    bit occ = 0;
    bit haz, rdy;
    logic [31:0] x1, x2;
    int rf = 0;
    @(negedge clk); clear_id(); rst = 1;
    @(negedge clk); rst = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      b.id_valid = $urandom_range(0, 3) != 0;
      b.id_rs_addr = 5'($urandom_range(0, 3)); b.id_rt_addr = 5'($urandom_range(0, 3));
      b.id_rs_data = $urandom; b.id_rt_data = $urandom;
      b.id_use_rs = 1'($urandom); b.id_use_rt = 1'($urandom);
      b.id_imm = 16'($urandom); b.id_imm_zext = 1'($urandom);
      b.id_src_b_imm = 1'($urandom); b.id_src_a_shamt = 1'($urandom);
      b.id_shamt = 5'($urandom); b.id_alu_op = 4'($urandom);
      b.id_dest_addr = 5'($urandom_range(0, 3));
      b.id_reg_write = 1'($urandom); b.id_is_load = 1'($urandom);
      b.flush = $urandom_range(0, 15) == 0;
      b.mem_reg_write = 1'($urandom); b.mem_dest_addr = 5'($urandom_range(0, 3)); b.mem_result = $urandom;
      b.wb_reg_write = 1'($urandom); b.wb_dest_addr = 5'($urandom_range(0, 3)); b.wb_result = $urandom;
      b.ex_ready = $urandom_range(0, 3) != 0;
      #1;
      haz = occ && e.ld && hit(e.dest);
      if (!FWD) haz = haz || (occ && e.rw && hit(e.dest)) || (b.mem_reg_write && hit(b.mem_dest_addr));
      rdy = !b.flush && !haz && (!occ || b.ex_ready);
      x1 = (FWD && e.a_reg) ? fwd_m(e.rs, e.v1) : e.v1;
      x2 = (FWD && e.b_reg) ? fwd_m(e.rt, e.v2) : e.v2;
      tests++; if (b.id_ready !== rdy) begin fails++; rf++; $display("FAIL rnd_ready c%0d: got %b want %b", c, b.id_ready, rdy); end
      tests++; if (b.ex_valid !== occ) begin fails++; rf++; $display("FAIL rnd_valid c%0d: got %b want %b", c, b.ex_valid, occ); end
      tests++; if (b.ex_in1 !== x1 || b.ex_in2 !== x2) begin fails++; rf++; $display("FAIL rnd_operands c%0d: got %h/%h want %h/%h", c, b.ex_in1, b.ex_in2, x1, x2); end
      tests++; if (b.ex_op !== e.op || b.ex_dest_addr !== e.dest) begin fails++; rf++; $display("FAIL rnd_opdest c%0d: got %h/%0d want %h/%0d", c, b.ex_op, b.ex_dest_addr, e.op, e.dest); end
      tests++; if (b.ex_reg_write !== (occ && e.rw) || b.ex_is_load !== (occ && e.ld)) begin fails++; rf++; $display("FAIL rnd_flags c%0d: got %b/%b want %b/%b", c, b.ex_reg_write, b.ex_is_load, occ && e.rw, occ && e.ld); end
      if (b.flush) occ = 0;
      else if (b.id_valid && rdy) begin
        ne.a_reg = !b.id_src_a_shamt;
        ne.b_reg = !b.id_src_b_imm;
        ne.v1 = b.id_src_a_shamt ? 32'(b.id_shamt) : (b.id_rs_addr == 0 ? 32'h0 : b.id_rs_data);
        ne.v2 = b.id_src_b_imm ? (b.id_imm_zext ? 32'(b.id_imm) : 32'($signed(b.id_imm)))
                               : (b.id_rt_addr == 0 ? 32'h0 : b.id_rt_data);
        ne.rs = b.id_rs_addr; ne.rt = b.id_rt_addr; ne.dest = b.id_dest_addr;
        ne.op = b.id_alu_op; ne.rw = b.id_reg_write; ne.ld = b.id_is_load;
        e = ne; occ = 1;
      end else if (b.ex_ready) occ = 0;
      if (rf > 20) break;
    end
  endtask
  initial begin
    clear_id();
    b.ex_ready = 1;
    test_reset();
    idle(); test_addi();
    idle(); test_ori();
    idle(); test_sll();
    idle(); test_back_to_back();
    idle(); test_load_use();
    idle(); test_producer_hazard();
`ifdef EX_FWD_EN
    idle(); test_fwd_priority();
`endif
    idle(); test_flush();
    idle(); test_async_reset();
    idle(); test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
